// File: rtl/frame_serializer.sv
// frame_serializer: captures an NROW x NCOL frame per handshake and streams it word by word, row-major.
// Define FRAME_SERIALIZER_SKID_EN to add a shadow frame so back-to-back frames stream with no bubble.
module frame_serializer #(
    parameter int unsigned DW   = 11,
    parameter int unsigned NROW = 2,
    parameter int unsigned NCOL = 4,
    localparam int unsigned RW  = (NROW > 1) ? $clog2(NROW) : 1,
    localparam int unsigned CW  = (NCOL > 1) ? $clog2(NCOL) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data [NROW][NCOL],
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data,
    output logic [RW-1:0] o_row,
    output logic [CW-1:0] o_col,
    output logic          o_last
);

    localparam logic [RW-1:0] RowLast = RW'(NROW - 1);
    localparam logic [CW-1:0] ColLast = CW'(NCOL - 1);

    typedef enum logic {StIdle, StSend} state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [DW-1:0] r_active [NROW][NCOL];
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;

    logic          w_in_hs;
    logic          w_out_hs;
    logic          w_last_hs;
    logic          w_load_in;
    logic          w_load_shadow;
    logic [RW-1:0] w_row_nxt;
    logic [CW-1:0] w_col_nxt;
    logic [DW-1:0] w_shadow_first;

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_row     = r_row;
    assign o_col     = r_col;
    assign o_last    = r_valid && (r_row == RowLast) && (r_col == ColLast);

    assign w_in_hs   = i_valid && i_ready;
    assign w_out_hs  = r_valid && o_ready;
    assign w_last_hs = w_out_hs && o_last;

`ifdef FRAME_SERIALIZER_SKID_EN
    logic [DW-1:0] r_shadow [NROW][NCOL];
    logic          r_shadow_full;
    logic          w_shadow_wr;

    assign i_ready        = !r_shadow_full;
    assign w_load_shadow  = w_last_hs && r_shadow_full;
    // A frame offered while the last word leaves (shadow empty) goes straight to active.
    assign w_load_in      = w_in_hs && ((r_state == StIdle) || w_last_hs);
    assign w_shadow_wr    = w_in_hs && (r_state == StSend) && !w_last_hs;
    assign w_shadow_first = r_shadow[0][0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow_full <= 1'b0;
            for (int unsigned r = 0; r < NROW; r++) begin
                for (int unsigned c = 0; c < NCOL; c++) begin
                    r_shadow[r][c] <= '0;
                end
            end
        end else begin
            if (w_shadow_wr) begin
                r_shadow      <= i_data;
                r_shadow_full <= 1'b1;
            end else if (w_load_shadow) begin
                r_shadow_full <= 1'b0;
            end
        end
    end
`else
    assign i_ready        = (r_state == StIdle);
    assign w_load_in      = w_in_hs;
    assign w_load_shadow  = 1'b0;
    assign w_shadow_first = '0;
`endif

    always_comb begin
        w_col_nxt = r_col + 1'b1;
        w_row_nxt = r_row;
        if (r_col == ColLast) begin
            w_col_nxt = '0;
            w_row_nxt = (r_row == RowLast) ? '0 : r_row + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (w_in_hs) w_state_nxt = StSend;
            StSend: if (w_last_hs && !w_load_in && !w_load_shadow) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // o_data is registered: it is loaded with the word the index will point at next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_row   <= '0;
            r_col   <= '0;
            for (int unsigned r = 0; r < NROW; r++) begin
                for (int unsigned c = 0; c < NCOL; c++) begin
                    r_active[r][c] <= '0;
                end
            end
        end else begin
            r_valid <= (w_state_nxt == StSend);
            if (w_load_in) begin
                r_active <= i_data;
                r_data   <= i_data[0][0];
                r_row    <= '0;
                r_col    <= '0;
            end else if (w_load_shadow) begin
`ifdef FRAME_SERIALIZER_SKID_EN
                r_active <= r_shadow;
`endif
                r_data   <= w_shadow_first;
                r_row    <= '0;
                r_col    <= '0;
            end else if (w_out_hs) begin
                r_data   <= r_active[w_row_nxt][w_col_nxt];
                r_row    <= w_row_nxt;
                r_col    <= w_col_nxt;
            end
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: table-driven frames, directed corner sequences and random traffic
// checked against a word-queue scoreboard built from accepted frames.
module tb_frame_serializer;

    localparam int unsigned DW   = 11;
    localparam int unsigned NROW = 2;
    localparam int unsigned NCOL = 4;
    localparam int unsigned RW   = (NROW > 1) ? $clog2(NROW) : 1;
    localparam int unsigned CW   = (NCOL > 1) ? $clog2(NCOL) : 1;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data [NROW][NCOL];
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic [RW-1:0] o_row;
    logic [CW-1:0] o_col;
    logic          o_last;

    frame_serializer #(.DW(DW), .NROW(NROW), .NCOL(NCOL)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_row   (o_row),
        .o_col   (o_col),
        .o_last  (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [RW-1:0] r;
        logic [CW-1:0] c;
        logic          l;
    } word_t;

    word_t         exp_q[$];
    logic [DW-1:0] frm [NROW][NCOL];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted frame expands into NROW*NCOL expected words in row-major order.
    initial begin
        logic  hold_p;
        word_t hold_w;
        word_t w;
        hold_p = 1'b0;
        hold_w = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                hold_p = 1'b0;
            end else begin
                if (hold_p) begin
                    chk("hold_valid", o_valid, 1);
                    chk("hold_word", {o_data, o_row, o_col, o_last}, hold_w);
                end
                if (o_valid && o_ready) begin
                    chk("pop_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        w = exp_q.pop_front();
                        chk("word", {o_data, o_row, o_col, o_last}, w);
                    end
                end
                if (i_valid && i_ready) begin
                    for (int r = 0; r < NROW; r++) begin
                        for (int c = 0; c < NCOL; c++) begin
                            w.d = i_data[r][c];
                            w.r = RW'(r);
                            w.c = CW'(c);
                            w.l = (r == NROW - 1) && (c == NCOL - 1);
                            exp_q.push_back(w);
                        end
                    end
                end
                hold_p = o_valid && !o_ready;
                hold_w = {o_data, o_row, o_col, o_last};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // kind 0: base + row*NCOL + col, kind 1: constant base, kind 2: random
    task automatic fill(input int kind, input int base);
        for (int r = 0; r < NROW; r++) begin
            for (int c = 0; c < NCOL; c++) begin
                if (kind == 0)      frm[r][c] = DW'(base + r * NCOL + c);
                else if (kind == 1) frm[r][c] = DW'(base);
                else                frm[r][c] = ($urandom_range(0, 7) == 0) ? '1 : DW'($urandom);
            end
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the frame.
    task automatic send_frame();
        int t;
        t = 0;
        i_data  = frm;
        i_valid = 1'b1;
        @(negedge clk);
        while (!i_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("accept_in_time", t < 50, 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        o_ready = 1'b1;
        i_valid = 1'b0;
        @(negedge clk);
        while ((o_valid || exp_q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_empty"}, exp_q.size(), 0);
        chk({name, "_idle"}, o_valid, 0);
    endtask

    typedef struct {
        int          kind;
        int          base;
        logic [15:0] pat;
        int          exp_cyc;
        int          exp_first;
        int          exp_last;
    } vec_t;

    vec_t        vt[5];
    int          k;
    int          n;
    int          first_w;
    int          last_w;
    bit          done;
    int          hs;
    logic [19:0] trace;
    logic [19:0] exp_trace;

    initial begin
        // o_ready pattern bit k applies to the k-th cycle after the frame is captured.
        vt[0] = '{0, 1,    16'hFFFF, 8,  1,    8};
        vt[1] = '{0, 1,    16'hFFE9, 11, 1,    8};
        vt[2] = '{1, 2047, 16'hFFFF, 8,  2047, 2047};
        vt[3] = '{0, 500,  16'h5555, 15, 500,  507};
        vt[4] = '{0, 1000, 16'h8421, 32, 1000, 1007};

        rst     = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        fill(1, 0);
        i_data  = frm;

        #7;
        chk("reset_outputs", {o_valid, o_data, o_row, o_col, o_last}, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(negedge clk);
        chk("reset_i_ready", i_ready, 1);

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            fill(vt[i].kind, vt[i].base);
            send_frame();
            k    = 0;
            n    = 0;
            done = 1'b0;
            while (!done && k < 64) begin
                o_ready = vt[i].pat[k % 16];
                @(negedge clk);
                if (o_valid && o_ready) begin
                    n++;
                    if (n == 1) first_w = int'(o_data);
                    if (o_last) begin
                        done   = 1'b1;
                        last_w = int'(o_data);
                    end
                end
                k++;
                @(posedge clk);
                #1;
            end
            o_ready = 1'b0;
            chk("vec_cycles", k, vt[i].exp_cyc);
            chk("vec_count", n, NROW * NCOL);
            chk("vec_first", first_w, vt[i].exp_first);
            chk("vec_last", last_w, vt[i].exp_last);
            @(negedge clk);
            chk("vec_gap_valid", o_valid, 0);
            chk("vec_gap_ready", i_ready, 1);
        end

        // Second frame offered continuously while the first one streams.
        @(posedge clk);
        #1;
        fill(0, 1);
        i_data  = frm;
        i_valid = 1'b1;
        o_ready = 1'b1;
        @(negedge clk);
        hs = (i_valid && i_ready) ? 1 : 0;
        chk("b2b_first_accept", hs, 1);
        trace = '0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            if (hs == 1) begin
                fill(0, 101);
                i_data = frm;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            trace[t] = o_valid;
            if (i_valid && i_ready) hs++;
        end
`ifdef FRAME_SERIALIZER_SKID_EN
        exp_trace = 20'h0FFFF;
`else
        exp_trace = 20'h1FEFF;
`endif
        chk("b2b_valid_trace", trace, exp_trace);
        chk("b2b_frames", hs, 2);
        drain("b2b_drain");

        // New frame offered in exactly the cycle the last word is accepted.
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        fill(0, 1);
        send_frame();
        o_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        fill(0, 201);
        i_data  = frm;
        i_valid = 1'b1;
        @(negedge clk);
        chk("coin_last_word", {o_valid, o_last, o_data}, {1'b1, 1'b1, DW'(8)});
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
`ifdef FRAME_SERIALIZER_SKID_EN
        chk("coin_no_gap", {o_valid, o_data, o_row, o_col}, {1'b1, DW'(201), RW'(0), CW'(0)});
`else
        chk("coin_gap", {o_valid, i_ready}, {1'b0, 1'b1});
`endif
        drain("coin_drain");

        // Asynchronous reset in the middle of a frame.
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        fill(0, 20);
        send_frame();
        o_ready = 1'b1;
        n = 0;
        k = 0;
        while (n < 3 && k < 20) begin
            @(negedge clk);
            if (o_valid && o_ready) n++;
            k++;
            @(posedge clk);
            #1;
        end
        chk("midreset_progress", n, 3);
        chk("midreset_before", {o_valid, o_data}, {1'b1, DW'(23)});
        #1;
        rst = 1'b0;
        #1;
        chk("midreset_async", {o_valid, o_data, o_row, o_col, o_last}, 0);
        @(posedge clk);
        #3;
        rst     = 1'b1;
        o_ready = 1'b0;
        @(negedge clk);
        chk("midreset_after", {i_ready, o_valid}, {1'b1, 1'b0});
        @(posedge clk);
        #1;
        fill(0, 50);
        send_frame();
        @(negedge clk);
        chk("midreset_restart", {o_valid, o_data, o_row, o_col}, {1'b1, DW'(50), RW'(0), CW'(0)});
        drain("midreset_drain");

        // Random traffic; every emitted word is checked by the scoreboard.
        hs = 0;
        @(posedge clk);
        #1;
        fill(2, 0);
        i_data = frm;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk);
            #1;
            if (hs != 0) begin
                fill(2, 0);
                i_data = frm;
                hs     = 0;
            end
            i_valid = ($urandom_range(0, 2) != 0);
            o_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (i_valid && i_ready) hs = 1;
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
